// File: rtl/ifu_pcgen_if.sv
// Fetch-side bus bundle: redirect inputs, instruction-memory request/ack, and IDU instruction hand-off.
// The master modport is the PC generator; the slave modport is its surroundings.
interface ifu_pcgen_if;
  logic        rtu_global_flush;
  logic [63:0] rtu_ifu_flush_pc;
  logic        exu_ifu_bju_complete;
  logic        exu_ifu_bju_pcjump_vld;
  logic [63:0] exu_ifu_bju_pcjump_addr;
  logic        ifu_mem_req;
  logic [63:0] ifu_mem_addr;
  logic        mem_ifu_ack;
  logic [31:0] mem_ifu_inst;
  logic        ifu_idu_vld;
  logic [63:0] ifu_idu_pc;
  logic [31:0] ifu_idu_inst;
  logic        idu_ifu_ready;

  modport master (
    input  rtu_global_flush, rtu_ifu_flush_pc,
    input  exu_ifu_bju_complete, exu_ifu_bju_pcjump_vld, exu_ifu_bju_pcjump_addr,
    output ifu_mem_req, ifu_mem_addr,
    input  mem_ifu_ack, mem_ifu_inst,
    output ifu_idu_vld, ifu_idu_pc, ifu_idu_inst,
    input  idu_ifu_ready
  );

  modport slave (
    output rtu_global_flush, rtu_ifu_flush_pc,
    output exu_ifu_bju_complete, exu_ifu_bju_pcjump_vld, exu_ifu_bju_pcjump_addr,
    input  ifu_mem_req, ifu_mem_addr,
    output mem_ifu_ack, mem_ifu_inst,
    input  ifu_idu_vld, ifu_idu_pc, ifu_idu_inst,
    output idu_ifu_ready
  );
endinterface

// File: rtl/ifu_pcgen.sv
// Non-predicting fetch PC generator with a 2-entry instruction buffer toward IDU.
// Optional IFU_PCGEN_PERF_CNT_EN adds fetch and redirect event counters.
module ifu_pcgen #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst_clk,
`ifdef IFU_PCGEN_PERF_CNT_EN
  output logic [31:0]       ifu_perf_fetch_cnt,
  output logic [31:0]       ifu_perf_redirect_cnt,
`endif
  ifu_pcgen_if.master       bus
);

  typedef enum logic [1:0] {S_FETCH, S_BLOCK, S_KILL} state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_addr;
  logic        r_req;
  logic [1:0]  r_cnt;
  logic        r_wr;
  logic        r_rd;
  logic [63:0] r_fifo_pc   [2];
  logic [31:0] r_fifo_inst [2];

  state_t      w_state_n;
  logic [63:0] w_pc_n;
  logic [63:0] w_addr_n;
  logic        w_req_n;
  logic [1:0]  w_cnt_n;
  logic        w_ack;
  logic        w_push;
  logic        w_pop;
  logic        w_is_cf;
  logic        w_vld;
  logic        w_redirect;

  assign w_ack   = bus.mem_ifu_ack & r_req;
  assign w_vld   = (r_cnt != 2'd0);
  assign w_pop   = w_vld & bus.idu_ifu_ready;
  assign w_is_cf = (bus.mem_ifu_inst[6:0] == 7'b1101111) ||
                   (bus.mem_ifu_inst[6:0] == 7'b1100111) ||
                   (bus.mem_ifu_inst[6:0] == 7'b1100011);

  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_push     = 1'b0;
    w_redirect = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_ack) begin
          w_push = 1'b1;
          if (w_is_cf) w_state_n = S_BLOCK;
          else         w_pc_n    = r_pc + 64'd4;
        end
      end
      S_BLOCK: begin
        if (bus.exu_ifu_bju_complete) begin
          w_redirect = bus.exu_ifu_bju_pcjump_vld;
          w_pc_n     = bus.exu_ifu_bju_pcjump_vld ? bus.exu_ifu_bju_pcjump_addr : r_pc + 64'd4;
          w_state_n  = S_FETCH;
        end
      end
      S_KILL: begin
        if (w_ack) w_state_n = S_FETCH;
      end
      default: w_state_n = S_FETCH;
    endcase

    // Flush wins over everything; an in-flight request must still be drained in KILL.
    if (bus.rtu_global_flush) begin
      w_push     = 1'b0;
      w_redirect = 1'b1;
      w_pc_n     = bus.rtu_ifu_flush_pc;
      w_state_n  = (r_req && !bus.mem_ifu_ack) ? S_KILL : S_FETCH;
    end

    if (bus.rtu_global_flush) w_cnt_n = 2'd0;
    else begin
      case ({w_push, w_pop})
        2'b10:   w_cnt_n = r_cnt + 2'd1;
        2'b01:   w_cnt_n = r_cnt - 2'd1;
        default: w_cnt_n = r_cnt;
      endcase
    end

    case (w_state_n)
      S_FETCH: w_req_n = (w_cnt_n != 2'd2) || (r_req && !w_ack);
      S_KILL:  w_req_n = 1'b1;
      default: w_req_n = 1'b0;
    endcase
    w_addr_n = (w_state_n == S_KILL) ? r_addr : w_pc_n;
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
      r_cnt   <= 2'd0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_pc[i]   <= 64'd0;
        r_fifo_inst[i] <= 32'd0;
      end
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_addr  <= w_addr_n;
      r_req   <= w_req_n;
      r_cnt   <= w_cnt_n;
      if (w_push) begin
        r_fifo_pc[r_wr]   <= r_pc;
        r_fifo_inst[r_wr] <= bus.mem_ifu_inst;
      end
      if (bus.rtu_global_flush) begin
        r_wr <= 1'b0;
        r_rd <= 1'b0;
      end else begin
        if (w_push) r_wr <= ~r_wr;
        if (w_pop)  r_rd <= ~r_rd;
      end
    end
  end

  assign bus.ifu_mem_req  = r_req;
  assign bus.ifu_mem_addr = r_addr;
  assign bus.ifu_idu_vld  = w_vld;
  assign bus.ifu_idu_pc   = r_fifo_pc[r_rd];
  assign bus.ifu_idu_inst = r_fifo_inst[r_rd];

`ifdef IFU_PCGEN_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_redir;

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      r_perf_fetch <= 32'd0;
      r_perf_redir <= 32'd0;
    end else begin
      if (w_push)     r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_redirect) r_perf_redir <= r_perf_redir + 32'd1;
    end
  end

  assign ifu_perf_fetch_cnt    = r_perf_fetch;
  assign ifu_perf_redirect_cnt = r_perf_redir;
`else
  logic w_unused_redirect;
  assign w_unused_redirect = w_redirect;
`endif

endmodule

// File: tb/tb_ifu_pcgen.sv
// Directed bench for ifu_pcgen: sequential fetch, JAL/BEQ/JALR blocking, buffer backpressure,
// flush into KILL with a late ack, flush with a full buffer, and PC wrap.
module tb_ifu_pcgen;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_8067;
  localparam logic [31:0] BEQ  = 32'h0000_0063;

  logic clk;
  logic rst_clk;
  int   n_tests;
  int   n_fail;

  ifu_pcgen_if bus();

`ifdef IFU_PCGEN_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_redir;
`endif

  ifu_pcgen #(.RESET_PC(RESET_PC)) dut (
    .clk                   (clk),
    .rst_clk               (rst_clk),
`ifdef IFU_PCGEN_PERF_CNT_EN
    .ifu_perf_fetch_cnt    (perf_fetch),
    .ifu_perf_redirect_cnt (perf_redir),
`endif
    .bus                   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_clk = 1'b0;
    bus.rtu_global_flush        = 1'b0;
    bus.rtu_ifu_flush_pc        = 64'd0;
    bus.exu_ifu_bju_complete    = 1'b0;
    bus.exu_ifu_bju_pcjump_vld  = 1'b0;
    bus.exu_ifu_bju_pcjump_addr = 64'd0;
    bus.mem_ifu_ack             = 1'b0;
    bus.mem_ifu_inst            = 32'd0;
    bus.idu_ifu_ready           = 1'b1;
    step(); step();
    chk("rst_req",  {63'd0, bus.ifu_mem_req}, 64'd0);
    chk("rst_addr", bus.ifu_mem_addr, RESET_PC);
    chk("rst_vld",  {63'd0, bus.ifu_idu_vld}, 64'd0);
    chk("rst_pc",   bus.ifu_idu_pc, 64'd0);
    chk("rst_inst", {32'd0, bus.ifu_idu_inst}, 64'd0);

    // Sequential fetch with an ack every cycle
    rst_clk = 1'b1;
    bus.mem_ifu_ack  = 1'b1;
    bus.mem_ifu_inst = ADDI;
    step();
    chk("seq_req0",  {63'd0, bus.ifu_mem_req}, 64'd1);
    chk("seq_addr0", bus.ifu_mem_addr, 64'h8000_0000);
    chk("seq_vld0",  {63'd0, bus.ifu_idu_vld}, 64'd0);
    step();
    chk("seq_addr1", bus.ifu_mem_addr, 64'h8000_0004);
    chk("seq_vld1",  {63'd0, bus.ifu_idu_vld}, 64'd1);
    chk("seq_pc1",   bus.ifu_idu_pc, 64'h8000_0000);
    chk("seq_inst1", {32'd0, bus.ifu_idu_inst}, {32'd0, ADDI});
    step();
    chk("seq_addr2", bus.ifu_mem_addr, 64'h8000_0008);
    chk("seq_pc2",   bus.ifu_idu_pc, 64'h8000_0004);
    bus.mem_ifu_inst = JAL;
    step();
    chk("jal_req",  {63'd0, bus.ifu_mem_req}, 64'd0);
    chk("jal_pc",   bus.ifu_idu_pc, 64'h8000_0008);
    chk("jal_inst", {32'd0, bus.ifu_idu_inst}, {32'd0, JAL});
    bus.mem_ifu_ack  = 1'b0;
    bus.mem_ifu_inst = ADDI;
    step();
    chk("blk_vld", {63'd0, bus.ifu_idu_vld}, 64'd0);
    chk("blk_req", {63'd0, bus.ifu_mem_req}, 64'd0);
    bus.exu_ifu_bju_complete    = 1'b1;
    bus.exu_ifu_bju_pcjump_vld  = 1'b1;
    bus.exu_ifu_bju_pcjump_addr = 64'h8000_1000;
    step();
    chk("jmp_req",  {63'd0, bus.ifu_mem_req}, 64'd1);
    chk("jmp_addr", bus.ifu_mem_addr, 64'h8000_1000);
    bus.exu_ifu_bju_complete   = 1'b0;
    bus.exu_ifu_bju_pcjump_vld = 1'b0;
    bus.mem_ifu_ack            = 1'b1;
    step();
    chk("jmp_addr1", bus.ifu_mem_addr, 64'h8000_1004);
    chk("jmp_pc",    bus.ifu_idu_pc, 64'h8000_1000);

    // Flush with ack in the same cycle: ack dropped, refetch next cycle
    bus.rtu_global_flush = 1'b1;
    bus.rtu_ifu_flush_pc = 64'h8000_0010;
    step();
    chk("fl_vld",  {63'd0, bus.ifu_idu_vld}, 64'd0);
    chk("fl_req",  {63'd0, bus.ifu_mem_req}, 64'd1);
    chk("fl_addr", bus.ifu_mem_addr, 64'h8000_0010);
    bus.rtu_global_flush        = 1'b0;
    bus.mem_ifu_inst            = BEQ;
    bus.exu_ifu_bju_complete    = 1'b1;
    bus.exu_ifu_bju_pcjump_vld  = 1'b1;
    bus.exu_ifu_bju_pcjump_addr = 64'hDEAD_0000;
    step();
    chk("beq_req",  {63'd0, bus.ifu_mem_req}, 64'd0);
    chk("beq_vld",  {63'd0, bus.ifu_idu_vld}, 64'd1);
    chk("beq_pc",   bus.ifu_idu_pc, 64'h8000_0010);
    chk("beq_inst", {32'd0, bus.ifu_idu_inst}, {32'd0, BEQ});
    bus.mem_ifu_ack            = 1'b0;
    bus.exu_ifu_bju_pcjump_vld = 1'b0;
    step();
    chk("nt_req",  {63'd0, bus.ifu_mem_req}, 64'd1);
    chk("nt_addr", bus.ifu_mem_addr, 64'h8000_0014);
    bus.exu_ifu_bju_complete = 1'b0;

    // Backpressure: fill the buffer, then drain in order
    rst_clk = 1'b0;
    #1;
    chk("rst2_req", {63'd0, bus.ifu_mem_req}, 64'd0);
    bus.idu_ifu_ready = 1'b0;
    bus.mem_ifu_ack   = 1'b1;
    bus.mem_ifu_inst  = ADDI;
    rst_clk = 1'b1;
    step();
    chk("bp_addr0", bus.ifu_mem_addr, 64'h8000_0000);
    step();
    chk("bp_addr1", bus.ifu_mem_addr, 64'h8000_0004);
    chk("bp_pc0",   bus.ifu_idu_pc, 64'h8000_0000);
    step();
    chk("bp_full_req", {63'd0, bus.ifu_mem_req}, 64'd0);
    chk("bp_full_pc",  bus.ifu_idu_pc, 64'h8000_0000);
    step();
    chk("bp_hold_req", {63'd0, bus.ifu_mem_req}, 64'd0);
    chk("bp_hold_vld", {63'd0, bus.ifu_idu_vld}, 64'd1);
    bus.idu_ifu_ready = 1'b1;
    bus.mem_ifu_ack   = 1'b0;
    step();
    chk("bp_res_req",  {63'd0, bus.ifu_mem_req}, 64'd1);
    chk("bp_res_addr", bus.ifu_mem_addr, 64'h8000_0008);
    chk("bp_pc1",      bus.ifu_idu_pc, 64'h8000_0004);
    step();
    chk("bp_empty_vld", {63'd0, bus.ifu_idu_vld}, 64'd0);

    // Delayed ack, flush while outstanding -> KILL discards the late ack
    step(); step();
    chk("dl_req",  {63'd0, bus.ifu_mem_req}, 64'd1);
    chk("dl_addr", bus.ifu_mem_addr, 64'h8000_0008);
    bus.rtu_global_flush = 1'b1;
    bus.rtu_ifu_flush_pc = 64'h8000_2000;
    step();
    chk("kill_req",  {63'd0, bus.ifu_mem_req}, 64'd1);
    chk("kill_addr", bus.ifu_mem_addr, 64'h8000_0008);
    bus.rtu_global_flush = 1'b0;
    step();
    chk("kill_addr2", bus.ifu_mem_addr, 64'h8000_0008);
    bus.mem_ifu_ack = 1'b1;
    step();
    chk("kill_vld",  {63'd0, bus.ifu_idu_vld}, 64'd0);
    chk("kill_addr3", bus.ifu_mem_addr, 64'h8000_2000);
    bus.mem_ifu_ack   = 1'b0;
    bus.idu_ifu_ready = 1'b0;
    step();
    chk("kill_vld2", {63'd0, bus.ifu_idu_vld}, 64'd0);
    chk("kill_req2", {63'd0, bus.ifu_mem_req}, 64'd1);

    // Flush with one entry buffered and ack in the flush cycle
    bus.mem_ifu_ack = 1'b1;
    step();
    chk("f1_pc",   bus.ifu_idu_pc, 64'h8000_2000);
    chk("f1_addr", bus.ifu_mem_addr, 64'h8000_2004);
    bus.rtu_global_flush = 1'b1;
    bus.rtu_ifu_flush_pc = 64'h8000_3000;
    step();
    chk("f1_vld",   {63'd0, bus.ifu_idu_vld}, 64'd0);
    chk("f1_addr2", bus.ifu_mem_addr, 64'h8000_3000);
    bus.rtu_global_flush = 1'b0;
    step();
    chk("f2_pc", bus.ifu_idu_pc, 64'h8000_3000);
    step();
    chk("f2_full_req", {63'd0, bus.ifu_mem_req}, 64'd0);
    // Flush with a full buffer and ack asserted
    bus.rtu_global_flush = 1'b1;
    bus.rtu_ifu_flush_pc = 64'h8000_2000;
    step();
    chk("f2_vld",  {63'd0, bus.ifu_idu_vld}, 64'd0);
    chk("f2_req",  {63'd0, bus.ifu_mem_req}, 64'd1);
    chk("f2_addr", bus.ifu_mem_addr, 64'h8000_2000);

    // Flush while KILL keeps KILL, pc follows the latest flush
    bus.mem_ifu_ack      = 1'b0;
    bus.rtu_ifu_flush_pc = 64'h8000_4000;
    step();
    chk("kk_addr", bus.ifu_mem_addr, 64'h8000_2000);
    chk("kk_vld",  {63'd0, bus.ifu_idu_vld}, 64'd0);
    bus.rtu_ifu_flush_pc = 64'h8000_5000;
    step();
    chk("kk_addr2", bus.ifu_mem_addr, 64'h8000_2000);
    bus.rtu_global_flush = 1'b0;
    bus.mem_ifu_ack      = 1'b1;
    bus.mem_ifu_inst     = JALR;
    bus.idu_ifu_ready    = 1'b1;
    step();
    chk("kk_addr3", bus.ifu_mem_addr, 64'h8000_5000);
    chk("kk_vld2",  {63'd0, bus.ifu_idu_vld}, 64'd0);
    step();
    chk("jalr_req",  {63'd0, bus.ifu_mem_req}, 64'd0);
    chk("jalr_pc",   bus.ifu_idu_pc, 64'h8000_5000);
    chk("jalr_inst", {32'd0, bus.ifu_idu_inst}, {32'd0, JALR});
    bus.mem_ifu_ack             = 1'b0;
    bus.exu_ifu_bju_complete    = 1'b1;
    bus.exu_ifu_bju_pcjump_vld  = 1'b1;
    bus.exu_ifu_bju_pcjump_addr = 64'h0000_0000_1234_5678;
    step();
    chk("jalr_addr", bus.ifu_mem_addr, 64'h0000_0000_1234_5678);
    bus.exu_ifu_bju_complete   = 1'b0;
    bus.exu_ifu_bju_pcjump_vld = 1'b0;

    // PC wrap at the top of the address space
    bus.rtu_global_flush = 1'b1;
    bus.rtu_ifu_flush_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    bus.mem_ifu_ack      = 1'b1;
    bus.mem_ifu_inst     = ADDI;
    step();
    chk("wrap_addr0", bus.ifu_mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_vld0",  {63'd0, bus.ifu_idu_vld}, 64'd0);
    bus.rtu_global_flush = 1'b0;
    step();
    chk("wrap_addr1", bus.ifu_mem_addr, 64'd0);
    chk("wrap_pc",    bus.ifu_idu_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
